// File: rtl/seq_divider_16by8_pkg.sv
// Shared widths, constants and FSM state type for the 16-by-8 sequential divider.
package div_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER_COUNT = 16;
  localparam int CNT_W      = 4;

  localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider_16by8_if.sv
// start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_16by8_if;
  logic                               start;
  logic [div_pkg::DIVIDEND_W-1:0]     dividend;
  logic [div_pkg::DIVISOR_W-1:0]      divisor;
  logic                               busy;
  logic                               done;
  logic [div_pkg::DIVIDEND_W-1:0]     quotient;
  logic [div_pkg::DIVISOR_W-1:0]      remainder;
  logic                               div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_16by8_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] i_rem,
  input  logic                 i_msb,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W-1:0] o_rem,
  output logic                 o_qbit
);
  logic [DIVISOR_W:0] w_partial;

  // The 9-bit partial keeps the compare exact when the running remainder is >= 128;
  // the difference always fits back in 8 bits, so only the low byte is kept.
  assign w_partial = {i_rem, i_msb};
  assign o_qbit    = (w_partial >= {1'b0, i_divisor});
  assign o_rem     = o_qbit ? (w_partial[DIVISOR_W-1:0] - i_divisor)
                            : w_partial[DIVISOR_W-1:0];
endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential unsigned restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional DIVIDER_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | 16 restoring iterations, r_cnt counts 15 down to 0
// DONE  | one-cycle done pulse, start accepted here for back-to-back
module seq_divider_16by8
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_16by8_if.slave  bus
);
  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [DIVIDEND_W-1:0]  r_dvd;
  logic [DIVIDEND_W-1:0]  r_quo;
  logic [DIVISOR_W-1:0]   r_rem;
  logic [DIVISOR_W-1:0]   r_dsr;
  logic [DIVIDEND_W-1:0]  r_quotient;
  logic [DIVISOR_W-1:0]   r_remainder;
  logic                   r_dbz;

  logic                   w_accept;
  logic                   w_dbz;
  logic                   w_early;
  logic [DIVISOR_W-1:0]   w_rem_nxt;
  logic                   w_qbit;
  logic [DIVIDEND_W-1:0]  w_quo_nxt;

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_dbz    = (bus.divisor == '0);

`ifdef DIVIDER_EARLY_EXIT_EN
  assign w_early  = !w_dbz && (bus.dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, bus.divisor});
`else
  assign w_early  = 1'b0;
`endif

  div_step u_step (
    .i_rem     (r_rem),
    .i_msb     (r_dvd[DIVIDEND_W-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_quo_nxt = {r_quo[DIVIDEND_W-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = (w_dbz || w_early) ? DONE : RUN;
      end
      RUN: begin
        if (r_cnt == '0) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_accept) w_state_nxt = (w_dbz || w_early) ? DONE : RUN;
        else          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= bus.dividend;
      r_dsr <= bus.divisor;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= CNT_W'(ITER_COUNT - 1);
      // Shortcut cases go straight to DONE, so their results are written here.
      if (w_dbz) begin
        r_quotient  <= DBZ_QUOTIENT;
        r_remainder <= bus.dividend[DIVISOR_W-1:0];
        r_dbz       <= 1'b1;
      end else if (w_early) begin
        r_quotient  <= '0;
        r_remainder <= bus.dividend[DIVISOR_W-1:0];
        r_dbz       <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_dvd <= r_dvd << 1;
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_quotient  <= w_quo_nxt;
        r_remainder <= w_rem_nxt;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed scoreboard bench for seq_divider_16by8; honours DIVIDER_EARLY_EXIT_EN for latency expectations.
module tb_seq_divider_16by8;
  logic clk;
  logic rst_n;

  seq_divider_16by8_if u_if ();

  seq_divider_16by8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = a / {8'd0, b};
      e.r   = 8'(a % {8'd0, b});
      e.dbz = 1'b0;
      e.lat = 17;
`ifdef DIVIDER_EARLY_EXIT_EN
      if (a < {8'd0, b}) e.lat = 1;
`endif
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is held for exactly the accept edge; on return the bench sits in cycle N+1.
  task automatic drive_start(input logic [15:0] a, input logic [7:0] b);
    u_if.dividend = a;
    u_if.divisor  = b;
    u_if.start    = 1'b1;
    push_exp(a, b);
    tick();
    u_if.start = 1'b0;
  endtask

  task automatic run_check(input int k0);
    int   k;
    exp_t e;
    k = k0;
    while (u_if.done !== 1'b1 && k < 40) begin
      chk("busy_run", {31'd0, u_if.busy}, 32'd1);
      tick();
      k++;
    end
    chk("done_seen", {31'd0, u_if.done}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency",     32'(k), 32'(e.lat));
    chk("quotient",    {16'd0, u_if.quotient}, {16'd0, e.q});
    chk("remainder",   {24'd0, u_if.remainder}, {24'd0, e.r});
    chk("div_by_zero", {31'd0, u_if.div_by_zero}, {31'd0, e.dbz});
    chk("busy_at_done", {31'd0, u_if.busy}, 32'd0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b);
    drive_start(a, b);
    run_check(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, u_if.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, u_if.done}, 32'd0);
    chk({tag, "_quo"},  {16'd0, u_if.quotient}, 32'd0);
    chk({tag, "_rem"},  {24'd0, u_if.remainder}, 32'd0);
    chk({tag, "_dbz"},  {31'd0, u_if.div_by_zero}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    rst_n         = 1'b0;
    u_if.start    = 1'b0;
    u_if.dividend = '0;
    u_if.divisor  = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    do_op(16'd25, 8'd5);
    repeat (3) tick();
    chk("hold_quo",  {16'd0, u_if.quotient}, 32'd5);
    chk("hold_done", {31'd0, u_if.done}, 32'd0);

    // Back-to-back: start stays high through RUN (ignored) and through done (accepted).
    u_if.dividend = 16'd200;
    u_if.divisor  = 8'd2;
    u_if.start    = 1'b1;
    push_exp(16'd200, 8'd2);
    tick();
    u_if.dividend = 16'd1000;
    u_if.divisor  = 8'd7;
    push_exp(16'd1000, 8'd7);
    run_check(1);
    tick();
    u_if.start = 1'b0;
    run_check(1);
    tick();

    do_op(16'd65535, 8'd255);
    tick();
    do_op(16'd65535, 8'd1);
    tick();

    do_op(16'h1234, 8'd0);
    tick();
    do_op(16'd100, 8'd3);
    tick();

    do_op(16'd3, 8'd10);
    tick();

    // Reset in cycle N+8 discards the operation; no done may follow.
    u_if.dividend = 16'd40000;
    u_if.divisor  = 8'd99;
    u_if.start    = 1'b1;
    tick();
    u_if.start = 1'b0;
    repeat (7) tick();
    chk("mid_run_busy", {31'd0, u_if.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (u_if.done === 1'b1) done_cnt++;
    end
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);
    do_op(16'd60000, 8'd250);
    tick();

    // A start pulse with different operands during RUN must not disturb the result.
    drive_start(16'd50000, 8'd123);
    repeat (4) tick();
    u_if.dividend = 16'd9999;
    u_if.divisor  = 8'd3;
    u_if.start    = 1'b1;
    tick();
    u_if.start = 1'b0;
    run_check(6);
    tick();
    chk("idle_after_done_busy", {31'd0, u_if.busy}, 32'd0);
    chk("idle_after_done_done", {31'd0, u_if.done}, 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
